// File: rtl/keypad_word_ctrl.sv
// keypad_word_ctrl
//   Turns debounced keypad presses into a word. Digits are appended to a character
//   buffer, star clears the word, and hash hands a non-empty word downstream over a
//   valid/ready handshake. Presses and releases both need DEBOUNCE_CYC consecutive
//   identical samples before they count.
//
//   Ports
//     clk         clock; all state updates on the rising edge
//     reset       synchronous, active-high
//     key_down    scanner level, 1 while any key is held
//     key_code    scanner code: 0-9 digit, 4'hA star, 4'hB hash, others ignored
//     word_ready  downstream accepts the presented word
//     word_valid  word_data/word_len hold a submitted word
//     word_data   char i at bits [i*CODE_W +: CODE_W]; slots at index >= word_len are 0
//     word_len    live character count, 0..MAX_LEN
//     key_strobe  one-cycle pulse per digit written into the buffer
//     overflow    sticky, set by a digit arriving while the buffer is full
module keypad_word_ctrl #(
  parameter int MAX_LEN      = 5,
  parameter int CODE_W       = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_down,
  input  logic [CODE_W-1:0]         key_code,
  input  logic                      word_ready,
  output logic                      word_valid,
  output logic [MAX_LEN*CODE_W-1:0] word_data,
  output logic [2:0]                word_len,
  output logic                      key_strobe,
  output logic                      overflow
);

  localparam int                BUF_W      = MAX_LEN * CODE_W;
  localparam int                DEB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
  // Value held by the counter when the final qualifying sample arrives.
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]        MAX_LEN_L  = 3'(MAX_LEN);
  localparam logic [CODE_W-1:0] CODE_NINE  = CODE_W'(9);
  localparam logic [CODE_W-1:0] CODE_STAR  = CODE_W'(10);
  localparam logic [CODE_W-1:0] CODE_HASH  = CODE_W'(11);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    DEB_REL   = 3'd3,
    SUBMIT    = 3'd4
  } state_t;

  state_t              state_r,  state_s;
  logic [DEB_W-1:0]    deb_r,    deb_s;
  logic [CODE_W-1:0]   code_r,   code_s;
  logic [BUF_W-1:0]    buf_r,    buf_s;
  logic [2:0]          len_r,    len_s;
  logic                strobe_r, strobe_s;
  logic                ovf_r,    ovf_s;
  logic                valid_r,  valid_s;

  // State and datapath registers, all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      deb_r    <= {DEB_W{1'b0}};
      code_r   <= {CODE_W{1'b0}};
      buf_r    <= {BUF_W{1'b0}};
      len_r    <= 3'd0;
      strobe_r <= 1'b0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      deb_r    <= deb_s;
      code_r   <= code_s;
      buf_r    <= buf_s;
      len_r    <= len_s;
      strobe_r <= strobe_s;
      ovf_r    <= ovf_s;
      valid_r  <= valid_s;
    end
  end

  // Next-state and next-datapath logic for the entry sequencer.
  always_comb begin
    state_s  = state_r;
    deb_s    = deb_r;
    code_s   = code_r;
    buf_s    = buf_r;
    len_s    = len_r;
    strobe_s = 1'b0;
    ovf_s    = ovf_r;
    valid_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (key_down) begin
          code_s  = key_code;
          deb_s   = DEB_ONE;
          state_s = DEB_PRESS;
        end else begin
          state_s = IDLE;
        end
      end

      DEB_PRESS: begin
        // A dropout or a code change abandons the press with no side effects.
        if (!key_down || (key_code != code_r)) begin
          state_s = IDLE;
        end else if (deb_r == DEB_LAST) begin
          deb_s   = deb_r + DEB_ONE;
          state_s = HELD;
          if (code_r <= CODE_NINE) begin
            if (len_r < MAX_LEN_L) begin
              buf_s[len_r*CODE_W +: CODE_W] = code_r;
              len_s    = len_r + 3'd1;
              strobe_s = 1'b1;
            end else begin
              ovf_s = 1'b1;
            end
          end else if (code_r == CODE_STAR) begin
            buf_s = {BUF_W{1'b0}};
            len_s = 3'd0;
            ovf_s = 1'b0;
          end else if ((code_r == CODE_HASH) && (len_r != 3'd0)) begin
            state_s = SUBMIT;
            valid_s = 1'b1;
          end else begin
            // Empty-word hash and unknown codes are swallowed.
            state_s = HELD;
          end
        end else begin
          deb_s = deb_r + DEB_ONE;
        end
      end

      HELD: begin
        if (!key_down) begin
          deb_s   = DEB_ONE;
          state_s = DEB_REL;
        end else begin
          state_s = HELD;
        end
      end

      DEB_REL: begin
        if (key_down) begin
          state_s = HELD;
        end else if (deb_r == DEB_LAST) begin
          deb_s   = {DEB_W{1'b0}};
          state_s = IDLE;
        end else begin
          deb_s = deb_r + DEB_ONE;
        end
      end

      SUBMIT: begin
        // Keypad is ignored here; returning via HELD means a key still held
        // must be released before the next press is qualified.
        if (valid_r && word_ready) begin
          buf_s   = {BUF_W{1'b0}};
          len_s   = 3'd0;
          ovf_s   = 1'b0;
          valid_s = 1'b0;
          state_s = HELD;
        end else begin
          valid_s = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign word_valid = valid_r;
  assign word_data  = buf_r;
  assign word_len   = len_r;
  assign key_strobe = strobe_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_keypad_word_ctrl.sv
module tb_keypad_word_ctrl;

  localparam int MAX_LEN = 5;
  localparam int CODE_W  = 4;
  localparam int DEB     = 4;
  localparam int DW      = MAX_LEN * CODE_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_down = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          word_ready = 1'b0;
  logic          word_valid;
  logic [DW-1:0] word_data;
  logic [2:0]    word_len;
  logic          key_strobe;
  logic          overflow;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    len;
  } exp_t;

  exp_t strobe_q[$];
  exp_t word_q[$];
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;

  keypad_word_ctrl #(.MAX_LEN(MAX_LEN), .CODE_W(CODE_W), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .reset(reset), .key_down(key_down), .key_code(key_code),
    .word_ready(word_ready), .word_valid(word_valid), .word_data(word_data),
    .word_len(word_len), .key_strobe(key_strobe), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a key for 'hold' cycles then release long enough to return to IDLE.
  task automatic press(input logic [3:0] code, input int hold);
    key_down = 1'b1;
    key_code = code;
    tick(hold);
    key_down = 1'b0;
    tick(DEB + 2);
  endtask

  task automatic push_strobe(input logic [DW-1:0] d, input logic [2:0] l);
    exp_t e;
    e.data = d;
    e.len  = l;
    strobe_q.push_back(e);
  endtask

  // Monitor: every strobe and every handshake must match the next expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_strobe) begin
        strobe_cnt++;
        if (strobe_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = strobe_q.pop_front();
          check("strobe_len", 32'(word_len), 32'(e.len));
          check("strobe_data", 32'(word_data), 32'(e.data));
        end
      end
      if (word_valid && word_ready) begin
        if (word_q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = word_q.pop_front();
          check("word_len", 32'(word_len), 32'(e.len));
          check("word_data", 32'(word_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    exp_t w;
    int   sc;

    // 1: reset with a key held
    key_down = 1'b1;
    key_code = 4'd7;
    tick(2);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data", 32'(word_data), 32'd0);
    check("rst_len", 32'(word_len), 32'd0);
    check("rst_strobe", 32'(key_strobe), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    key_down = 1'b0;
    reset = 1'b0;
    tick(3);

    // 2: digit 3, strobe exactly after the 4th sample
    push_strobe(20'h00003, 3'd1);
    key_down = 1'b1;
    key_code = 4'd3;
    tick(3);
    check("t2_early_strobe", 32'(key_strobe), 32'd0);
    tick(1);
    check("t2_strobe", 32'(key_strobe), 32'd1);
    tick(1);
    check("t2_strobe_1cyc", 32'(key_strobe), 32'd0);
    tick(5);
    key_down = 1'b0;
    tick(DEB + 2);
    check("t2_len", 32'(word_len), 32'd1);
    check("t2_data", 32'(word_data[3:0]), 32'd3);
    check("t2_one_strobe", 32'(strobe_cnt), 32'd1);

    // 3: bouncing press never qualifies; clear the word first
    press(4'hA, 6);
    check("t3_star_len", 32'(word_len), 32'd0);
    sc = strobe_cnt;
    key_code = 4'd2;
    key_down = 1'b1; tick(1);
    key_down = 1'b1; tick(1);
    key_down = 1'b0; tick(1);
    key_down = 1'b1; tick(1);
    key_down = 1'b1; tick(1);
    key_down = 1'b1; tick(1);
    key_down = 1'b0; tick(DEB + 2);
    check("t3_no_strobe", 32'(strobe_cnt), 32'(sc));
    check("t3_len", 32'(word_len), 32'd0);

    // 4: fill to MAX_LEN, overflow on the sixth digit, star clears all
    push_strobe(20'h00001, 3'd1);
    push_strobe(20'h00021, 3'd2);
    push_strobe(20'h00321, 3'd3);
    push_strobe(20'h04321, 3'd4);
    push_strobe(20'h54321, 3'd5);
    for (int d = 1; d <= 5; d++) begin
      press(4'(d), 6);
    end
    check("t4_ovf_before", 32'(overflow), 32'd0);
    press(4'd6, 6);
    check("t4_len", 32'(word_len), 32'd5);
    check("t4_data", 32'(word_data), 32'h54321);
    check("t4_ovf", 32'(overflow), 32'd1);
    press(4'hA, 6);
    check("t4_clr_len", 32'(word_len), 32'd0);
    check("t4_clr_data", 32'(word_data), 32'd0);
    check("t4_clr_ovf", 32'(overflow), 32'd0);

    // 5: 7,8 then hash, downstream stalls, digit during SUBMIT ignored
    push_strobe(20'h00007, 3'd1);
    push_strobe(20'h00087, 3'd2);
    press(4'd7, 6);
    press(4'd8, 6);
    press(4'hB, 6);
    tick(5);
    check("t5_valid_held", 32'(word_valid), 32'd1);
    check("t5_len", 32'(word_len), 32'd2);
    check("t5_data", 32'(word_data), 32'h00087);
    press(4'd9, 6);
    check("t5_ignored_len", 32'(word_len), 32'd2);
    check("t5_still_valid", 32'(word_valid), 32'd1);
    w.data = 20'h00087;
    w.len  = 3'd2;
    word_q.push_back(w);
    word_ready = 1'b1;
    tick(1);
    check("t5_valid_drop", 32'(word_valid), 32'd0);
    check("t5_len_clr", 32'(word_len), 32'd0);
    check("t5_data_clr", 32'(word_data), 32'd0);
    word_ready = 1'b0;
    tick(DEB + 2);

    // 6: reset during SUBMIT, then an empty-word hash does nothing
    push_strobe(20'h00005, 3'd1);
    press(4'd5, 6);
    press(4'hB, 6);
    check("t6_valid", 32'(word_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_valid", 32'(word_valid), 32'd0);
    check("t6_rst_len", 32'(word_len), 32'd0);
    reset = 1'b0;
    tick(2);
    press(4'hB, 6);
    tick(3);
    check("t6_hash_empty", 32'(word_valid), 32'd0);
    check("t6_len", 32'(word_len), 32'd0);

    check("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    check("word_q_empty", 32'(word_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
